// File: rtl/boot_loader_ctrl_if.sv
// Boot loader bus interface.
// Groups the transmitter handshake (syn -> ack/instr/last) and the IMEM write port.
// master: boot loader side, slave: transmitter + IMEM side.
interface boot_loader_ctrl_if #(
  parameter int IWIDTH = 32,
  parameter int AWIDTH = 6
) ();
  logic              bl_o_syn;
  logic [IWIDTH-1:0] bl_i_instr;
  logic              bl_i_ack;
  logic              bl_i_last;
  logic              bl_o_we;
  logic [AWIDTH-1:0] bl_o_addr;
  logic [IWIDTH-1:0] bl_o_wdata;

  modport master (
    output bl_o_syn, bl_o_we, bl_o_addr, bl_o_wdata,
    input  bl_i_instr, bl_i_ack, bl_i_last
  );

  modport slave (
    input  bl_o_syn, bl_o_we, bl_o_addr, bl_o_wdata,
    output bl_i_instr, bl_i_ack, bl_i_last
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: pulls one word per syn/ack handshake from the instruction
// transmitter, writes it to IMEM and holds the core in reset until the last
// word lands. Flags timeout and overflow (and a bad checksum when enabled).
// Optional feature macro: BL_CHECKSUM_EN (running modulo-2**IWIDTH sum of the
// image, which must be zero on the last word). Undefined: bl_o_csum is 0.
module boot_loader_ctrl #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 36,
  parameter int AWIDTH  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic                bl_clk,
  input  logic                bl_rst,
  input  logic                bl_i_start,
  boot_loader_ctrl_if.master  bus,
  output logic [AWIDTH:0]     bl_o_count,
  output logic                bl_o_busy,
  output logic                bl_o_done,
  output logic                bl_o_err,
  output logic                bl_o_cpu_rstn,
  output logic [IWIDTH-1:0]   bl_o_csum
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam logic [AWIDTH:0] COUNT_MAX  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] COUNT_ONE  = (AWIDTH + 1)'(1);

  state_t            r_state;
  logic              r_syn;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [IWIDTH-1:0] r_wdata;
  logic [AWIDTH:0]   r_count;
  logic [TW-1:0]     r_timer;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_cpu_rstn;

  logic [AWIDTH:0]   w_count_nxt;
  logic              w_sum_bad;

  assign w_count_nxt = r_count + COUNT_ONE;

`ifdef BL_CHECKSUM_EN
  logic [IWIDTH-1:0] r_csum;
  logic [IWIDTH-1:0] w_csum_nxt;

  // Modulo-2**IWIDTH accumulate; carries out of the top bit are dropped.
  function automatic logic [IWIDTH-1:0] f_csum_add(input logic [IWIDTH-1:0] a,
                                                   input logic [IWIDTH-1:0] b);
    return a + b;
  endfunction

  assign w_csum_nxt = f_csum_add(r_csum, bus.bl_i_instr);
  // A good image sums to zero including its last (compensating) word.
  assign w_sum_bad  = (w_csum_nxt != {IWIDTH{1'b0}});
  assign bl_o_csum  = r_csum;
`else
  assign w_sum_bad  = 1'b0;
  assign bl_o_csum  = {IWIDTH{1'b0}};
`endif

  // Sequencer FSM: one request outstanding at a time, every output registered.
  always_ff @(posedge bl_clk or negedge bl_rst) begin
    if (!bl_rst) begin
      r_state    <= ST_IDLE;
      r_syn      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= {AWIDTH{1'b0}};
      r_wdata    <= {IWIDTH{1'b0}};
      r_count    <= {(AWIDTH + 1){1'b0}};
      r_timer    <= {TW{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rstn <= 1'b0;
`ifdef BL_CHECKSUM_EN
      r_csum     <= {IWIDTH{1'b0}};
`endif
    end else begin
      // syn and we are single-cycle pulses unless re-armed below.
      r_syn <= 1'b0;
      r_we  <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Start (or restart) a load; busy loads never get here, so start is ignored then.
          if (bl_i_start) begin
            r_state    <= ST_REQ;
            r_syn      <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rstn <= 1'b0;
            r_count    <= {(AWIDTH + 1){1'b0}};
            r_timer    <= {TW{1'b0}};
`ifdef BL_CHECKSUM_EN
            r_csum     <= {IWIDTH{1'b0}};
`endif
          end else begin
            r_state <= r_state;
          end
        end
        ST_REQ: begin
          // syn is high during this cycle; any ack now is stale and ignored.
          r_state <= ST_WAIT;
          r_timer <= {TW{1'b0}};
        end
        ST_WAIT: begin
          if (bus.bl_i_ack) begin
            // Ack wins over a timeout in the same cycle.
            r_we    <= 1'b1;
            r_addr  <= r_count[AWIDTH-1:0];
            r_wdata <= bus.bl_i_instr;
            r_count <= w_count_nxt;
`ifdef BL_CHECKSUM_EN
            r_csum  <= w_csum_nxt;
`endif
            if (bus.bl_i_last) begin
              r_busy <= 1'b0;
              if (w_sum_bad) begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end else begin
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_cpu_rstn <= 1'b1;
              end
            end else if (w_count_nxt == COUNT_MAX) begin
              // Overflow: image longer than DEPTH; this word is still written.
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_REQ;
              r_syn   <= 1'b1;
            end
          end else if (r_timer == TIMER_LAST) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_cpu_rstn <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bl_o_syn   = r_syn;
  assign bus.bl_o_we    = r_we;
  assign bus.bl_o_addr  = r_addr;
  assign bus.bl_o_wdata = r_wdata;
  assign bl_o_count     = r_count;
  assign bl_o_busy      = r_busy;
  assign bl_o_done      = r_done;
  assign bl_o_err       = r_err;
  assign bl_o_cpu_rstn  = r_cpu_rstn;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: a transmitter model answers each syn
// one cycle later and pushes the expected IMEM write; a monitor pops and
// compares on every we. Checksum case compiled in with BL_CHECKSUM_EN.
module tb_boot_loader_ctrl;
  localparam int IWIDTH  = 32;
  localparam int AWIDTH  = 6;
  localparam int DEPTH   = 36;
  localparam int TIMEOUT = 16;

  logic              bl_clk     = 1'b0;
  logic              bl_rst     = 1'b1;
  logic              bl_i_start = 1'b0;
  logic [AWIDTH:0]   bl_o_count;
  logic              bl_o_busy;
  logic              bl_o_done;
  logic              bl_o_err;
  logic              bl_o_cpu_rstn;
  logic [IWIDTH-1:0] bl_o_csum;

  boot_loader_ctrl_if #(.IWIDTH(IWIDTH), .AWIDTH(AWIDTH)) bus ();

  boot_loader_ctrl #(.IWIDTH(IWIDTH), .DEPTH(DEPTH), .AWIDTH(AWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .bl_clk        (bl_clk),
    .bl_rst        (bl_rst),
    .bl_i_start    (bl_i_start),
    .bus           (bus),
    .bl_o_count    (bl_o_count),
    .bl_o_busy     (bl_o_busy),
    .bl_o_done     (bl_o_done),
    .bl_o_err      (bl_o_err),
    .bl_o_cpu_rstn (bl_o_cpu_rstn),
    .bl_o_csum     (bl_o_csum)
  );

  always #5 bl_clk = ~bl_clk;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [IWIDTH-1:0] data;
  } wr_t;

  int                n_checks  = 0;
  int                n_errors  = 0;
  logic [IWIDTH-1:0] img [0:63];
  wr_t               exp_q[$];
  int                last_idx  = 999;
  int                stall_at  = 64;
  int                tx_idx    = 0;
  bit                tx_pend   = 1'b0;
  int                syn_cnt   = 0;
  int                we_cnt    = 0;
  int                cyc       = 0;
  int                stall_cyc = -1;
  int                err_cyc   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Free-running cycle counter, stable when sampled on the falling edge.
  always @(posedge bl_clk) cyc <= cyc + 1;

  // Transmitter model: one word per syn, ack one cycle after syn; stalls from stall_at on.
  initial begin
    bus.bl_i_ack   = 1'b0;
    bus.bl_i_last  = 1'b0;
    bus.bl_i_instr = '0;
    forever begin
      @(negedge bl_clk);
      bus.bl_i_ack  = 1'b0;
      bus.bl_i_last = 1'b0;
      if (tx_pend && bl_rst) begin
        bus.bl_i_ack   = 1'b1;
        bus.bl_i_instr = img[tx_idx];
        bus.bl_i_last  = (tx_idx == last_idx);
        exp_q.push_back('{addr: tx_idx[AWIDTH-1:0], data: img[tx_idx]});
        tx_idx++;
      end
      tx_pend = 1'b0;
      if (bus.bl_o_syn === 1'b1) begin
        if (tx_idx >= stall_at) stall_cyc = cyc;
        else tx_pend = 1'b1;
      end
    end
  end

  // Monitor: compares every IMEM write against the scoreboard, counts syn, notes first err.
  initial begin
    wr_t e;
    forever begin
      @(negedge bl_clk);
      if (bus.bl_o_syn === 1'b1) syn_cnt++;
      if (bus.bl_o_we === 1'b1) begin
        we_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("we_addr", 64'(bus.bl_o_addr), 64'(e.addr));
          chk("we_data", 64'(bus.bl_o_wdata), 64'(e.data));
        end
      end
      if (bl_o_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge bl_clk);
  endtask

  task automatic prep(input int last_i, input int stall_i);
    last_idx  = last_i;
    stall_at  = stall_i;
    tx_idx    = 0;
    tx_pend   = 1'b0;
    exp_q.delete();
    syn_cnt   = 0;
    we_cnt    = 0;
    err_cyc   = -1;
    stall_cyc = -1;
  endtask

  task automatic pulse_start();
    bl_i_start = 1'b1;
    @(negedge bl_clk);
    bl_i_start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n = 0;
    while (bl_o_done !== 1'b1 && bl_o_err !== 1'b1 && n < budget) begin
      @(negedge bl_clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no done/err within %0d cycles", name, budget);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bl_o_count, bl_o_busy, bl_o_done, bl_o_err, bl_o_cpu_rstn, bl_o_csum,
                bus.bl_o_syn, bus.bl_o_we, bus.bl_o_addr}) | 64'(bus.bl_o_wdata);
  endfunction

  initial begin
    int we_before;
    int n;
    for (int i = 0; i < 64; i++) img[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;

    // 1. Reset with start low: everything zero, no syn for 20 cycles.
    #2 bl_rst = 1'b0;
    cycles(3);
    chk("reset_outputs", all_outs(), 64'd0);
    bl_rst = 1'b1;
    prep(999, 64);
    cycles(20);
    chk("idle_no_syn", 64'(syn_cnt), 64'd0);
    chk("idle_outputs", all_outs(), 64'd0);

    // 2. Full 36-word image, last on word 35; first we 3 cycles after start sampled.
    prep(35, 64);
    pulse_start();
    chk("syn_after_start", 64'(bus.bl_o_syn), 64'd1);
    chk("busy_in_load", 64'(bl_o_busy), 64'd1);
    cycles(1);
    chk("no_we_cycle2", 64'(bus.bl_o_we), 64'd0);
    cycles(1);
    chk("first_we_cycle3", 64'(bus.bl_o_we), 64'd1);
    wait_end("full_load", 200);
    cycles(2);
    chk("full_done", 64'(bl_o_done), 64'd1);
    chk("full_err", 64'(bl_o_err), 64'd0);
    chk("full_cpu_rstn", 64'(bl_o_cpu_rstn), 64'd1);
    chk("full_busy", 64'(bl_o_busy), 64'd0);
    chk("full_count", 64'(bl_o_count), 64'd36);
    chk("full_we_cnt", 64'(we_cnt), 64'd36);
    chk("full_syn_cnt", 64'(syn_cnt), 64'd36);
    chk("full_queue_empty", 64'(exp_q.size()), 64'd0);
`ifndef BL_CHECKSUM_EN
    chk("csum_tied_zero", 64'(bl_o_csum), 64'd0);
`endif

    // 3. Stall after word 4: err exactly TIMEOUT cycles after entering WAIT.
    prep(999, 5);
    pulse_start();
    chk("restart_clears_done", 64'({bl_o_done, bl_o_cpu_rstn}), 64'd0);
    wait_end("stall_load", 200);
    cycles(2);
    chk("stall_err", 64'(bl_o_err), 64'd1);
    chk("stall_done", 64'(bl_o_done), 64'd0);
    chk("stall_cpu_rstn", 64'(bl_o_cpu_rstn), 64'd0);
    chk("stall_count", 64'(bl_o_count), 64'd5);
    chk("stall_we_cnt", 64'(we_cnt), 64'd5);
    chk("stall_seen", 64'(stall_cyc >= 0 && err_cyc >= 0), 64'd1);
    // WAIT is entered on the edge after the unanswered syn was seen.
    chk("timeout_latency", 64'(err_cyc - (stall_cyc + 1)), 64'(TIMEOUT));

    // 4. last never asserted: err after the 36th write, no 37th syn.
    prep(999, 64);
    pulse_start();
    chk("restart_clears_err", 64'(bl_o_err), 64'd0);
    wait_end("overflow_load", 200);
    cycles(20);
    chk("ovf_err", 64'(bl_o_err), 64'd1);
    chk("ovf_done", 64'(bl_o_done), 64'd0);
    chk("ovf_count", 64'(bl_o_count), 64'd36);
    chk("ovf_we_cnt", 64'(we_cnt), 64'd36);
    chk("ovf_syn_cnt", 64'(syn_cnt), 64'd36);

    // 5. Reset mid-load at word 10, then a clean reload from address 0.
    prep(35, 64);
    pulse_start();
    n = 0;
    while (we_cnt < 10 && n < 100) begin
      @(negedge bl_clk);
      n++;
    end
    chk("reached_word10", 64'(we_cnt >= 10), 64'd1);
    we_before = we_cnt;
    bl_rst = 1'b0;
    #1;
    chk("midreset_outputs", all_outs(), 64'd0);
    cycles(3);
    chk("midreset_hold", all_outs(), 64'd0);
    chk("midreset_no_we", 64'(we_cnt), 64'(we_before));
    bl_rst = 1'b1;
    prep(35, 64);
    cycles(2);
    pulse_start();
    wait_end("reload", 200);
    cycles(2);
    chk("reload_done", 64'(bl_o_done), 64'd1);
    chk("reload_count", 64'(bl_o_count), 64'd36);
    chk("reload_we_cnt", 64'(we_cnt), 64'd36);

`ifdef BL_CHECKSUM_EN
    // 6. Checksum: good image sums to zero, bad one leaves 0xFFFFFFFF.
    img[0] = 32'h0000_0001;
    img[1] = 32'h0000_0002;
    img[2] = 32'hFFFF_FFFD;
    prep(2, 64);
    pulse_start();
    wait_end("csum_good", 50);
    cycles(2);
    chk("csum_good_done", 64'(bl_o_done), 64'd1);
    chk("csum_good_err", 64'(bl_o_err), 64'd0);
    chk("csum_good_val", 64'(bl_o_csum), 64'd0);
    chk("csum_good_count", 64'(bl_o_count), 64'd3);
    img[2] = 32'hFFFF_FFFC;
    prep(2, 64);
    pulse_start();
    wait_end("csum_bad", 50);
    cycles(2);
    chk("csum_bad_err", 64'(bl_o_err), 64'd1);
    chk("csum_bad_done", 64'(bl_o_done), 64'd0);
    chk("csum_bad_val", 64'(bl_o_csum), 64'h0000_0000_FFFF_FFFF);
    chk("csum_bad_we_cnt", 64'(we_cnt), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
